// File: rtl/mod_reduce_p25519_pkg.sv
// Shared constants and state encoding for the p = 2^(N-1) - C modular reducer.
// Everything is derived from N, C and NFOLD so the modulus is defined in one place.
package p25519_pkg;

  localparam int N     = 256;
  localparam int C     = 19;
  localparam int NFOLD = 3;
  localparam int XW    = 2 * N + 1;
  localparam int CNT_W = $clog2(NFOLD + 1);

  // 2^(N-1) - C written as (2^(N-1) - 1) - (C - 1) so it never needs an N+1-bit intermediate
  localparam logic [N-1:0] P = {1'b0, {(N-1){1'b1}}} - N'(C - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mod_reduce_p25519_if.sv
// Valid/ready bus between the multiplier, the reducer and the result consumer.
// The reducer sits on the slave modport.
interface mod_reduce_p25519_if;
  import p25519_pkg::*;

  logic [2*N-1:0] prod_in;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   res;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  modport master (
    output prod_in, in_valid, out_ready,
    input  in_ready, res, out_valid, busy
  );

  modport slave (
    input  prod_in, in_valid, out_ready,
    output in_ready, res, out_valid, busy
  );

endinterface

// File: rtl/mod_reduce_p25519_fold.sv
// One folding step x_lo + C*x_hi, using 2^(N-1) == C (mod p).
// C is a small constant, so C*x_hi is built from shifted copies of x_hi.
module p25519_fold
  import p25519_pkg::*;
#(
  parameter int FN = N,
  parameter int FC = C
) (
  input  logic [2*FN:0] x_in,
  output logic [2*FN:0] x_out
);

  localparam int FXW  = 2 * FN + 1;
  localparam int HW   = FXW - (FN - 1);
  localparam int PW   = HW + 6;
  localparam logic [5:0] C_BITS = 6'(FC);

  logic [FN-2:0] x_lo;
  logic [HW-1:0] x_hi;
  logic [PW-1:0] c_hi;

  assign x_lo = x_in[FN-2:0];
  assign x_hi = x_in[FXW-1:FN-1];

  always_comb begin
    c_hi = '0;
    for (int i = 0; i < 6; i++) begin
      if (C_BITS[i]) begin
        c_hi = c_hi + (PW'(x_hi) << i);
      end
    end
  end

  assign x_out = FXW'(c_hi) + FXW'(x_lo);

endmodule

// File: rtl/mod_reduce_p25519.sv
// Sequential reducer: latch the 2N-bit product, fold NFOLD times, one conditional
// subtract, then hold the canonical result until the consumer takes it.
module mod_reduce_p25519
  import p25519_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mod_reduce_p25519_if.slave   bus
);

  localparam logic [XW-1:0] P_X = XW'(P);

  state_e             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [XW-1:0]      x_fold;
  logic [CNT_W-1:0]   fold_cnt_q, fold_cnt_d;
  logic [N-1:0]       res_q, res_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  p25519_fold #(.FN(N), .FC(C)) u_fold (
    .x_in  (x_q),
    .x_out (x_fold)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    fold_cnt_d = fold_cnt_q;
    res_d      = res_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d        = XW'(bus.prod_in);
          fold_cnt_d = '0;
          state_d    = FOLD;
        end
      end
      FOLD: begin
        x_d        = x_fold;
        fold_cnt_d = fold_cnt_q + 1'b1;
        if (fold_cnt_q == CNT_W'(NFOLD - 1)) begin
          state_d = SUB;
        end
      end
      SUB: begin
        // After the folds x < 2^(N-1) < 2p, so a single subtract lands in [0, p-1]
        if (x_q >= P_X) begin
          res_d = N'(x_q - P_X);
        end else begin
          res_d = x_q[N-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      fold_cnt_q  <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      fold_cnt_q  <= fold_cnt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res       = res_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mod_reduce_p25519.sv
// Bench for mod_reduce_p25519: directed corner products, backpressure, mid-op reset,
// and random a*b streams checked against plain a*b % p.
module tb_mod_reduce_p25519;
  import p25519_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mod_reduce_p25519_if bus ();

  mod_reduce_p25519 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [511:0] p_ref;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) chk("ready_timeout", 512'(k), 512'(0));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Send one product, check latency and result, hold off the consumer for
  // 'hold' cycles, then release it and check the return to idle.
  task automatic do_op(input string tag, input logic [511:0] prod, input logic [255:0] exp,
                       input int hold);
    int lat;
    wait_ready();
    bus.prod_in  = prod;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Handshake cycle is t; out_valid is first visible in cycle t+NFOLD+2,
    // i.e. NFOLD+1 rising edges after the handshake edge.
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 512'(lat), 512'(NFOLD + 1));
    chk({tag, "_res"}, 512'(bus.res), 512'(exp));
    bus.out_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 512'(bus.out_valid), 512'(1));
      chk({tag, "_hold_res"}, 512'(bus.res), 512'(exp));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 512'(bus.out_valid), 512'(0));
    chk({tag, "_idle_ready"}, 512'(bus.in_ready), 512'(1));
  endtask

  initial begin
    logic [511:0] prod;
    logic [511:0] exp_full;
    logic [255:0] a, b, held;
    int lat;

    p_ref = (512'd1 << 255) - 512'd19;

    bus.prod_in   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
    chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_res", 512'(bus.res), 512'(0));
    chk("rst_busy", 512'(bus.busy), 512'(0));

    // Directed corner values
    do_op("zero", 512'd0, 256'd0, 0);
    do_op("p", p_ref, 256'd0, 1);
    do_op("pow255", 512'd1 << 255, 256'd19, 0);
    do_op("p_plus5", p_ref + 512'd5, 256'd5, 2);
    do_op("p_minus1", p_ref - 512'd1, 256'(p_ref - 512'd1), 0);
    do_op("all_ones", {512{1'b1}}, 256'd1443, 0);
    prod = (p_ref - 512'd1) * (p_ref - 512'd1);
    do_op("pm1_sq", prod, 256'd1, 0);

    // Backpressure with ignored input pulses
    wait_ready();
    a = rand256();
    b = rand256();
    prod = {256'd0, a} * {256'd0, b};
    exp_full = prod % p_ref;
    bus.prod_in  = prod;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_res", 512'(bus.res), exp_full);
    held = bus.res;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.prod_in  = {rand256(), rand256()};
      @(posedge clk); #1;
      chk("bp_held_res", 512'(bus.res), 512'(held));
      chk("bp_held_valid", 512'(bus.out_valid), 512'(1));
      chk("bp_in_ready", 512'(bus.in_ready), 512'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 512'(bus.out_valid), 512'(0));
    chk("bp_release_ready", 512'(bus.in_ready), 512'(1));
    @(posedge clk); #1;
    chk("bp_no_stale_accept", 512'(bus.busy), 512'(0));

    // Reset during the second fold cycle
    wait_ready();
    bus.prod_in  = {rand256(), rand256()};
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 512'(bus.in_ready), 512'(1));
    chk("midrst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("midrst_res", 512'(bus.res), 512'(0));
    chk("midrst_busy", 512'(bus.busy), 512'(0));
    do_op("after_rst", {512{1'b1}}, 256'd1443, 0);

    // Random a*b stream with random consumer stalls
    for (int n = 0; n < 1000; n++) begin
      a = rand256();
      b = rand256();
      prod = {256'd0, a} * {256'd0, b};
      exp_full = prod % p_ref;
      do_op("rand", prod, exp_full[255:0], int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
